// File: rtl/dsp_pkg.sv
// dsp_pkg: shared widths, opcode constants and the decoded-operation type
// used by the dsp_core accumulator machine.
package dsp_pkg;

    localparam int unsigned ACC_W  = 32;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned PC_W   = 12;
    localparam int unsigned DMA_W  = 7;

    // Shift-class opcodes are matched on word[15:12]; s = word[11:8].
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_LAC  = 4'h2;

    // Byte opcodes, matched on word[15:8].
    localparam logic [7:0] OP_ADDH = 8'h60;
    localparam logic [7:0] OP_ADDS = 8'h61;
    localparam logic [7:0] OP_LT   = 8'h6A;
    localparam logic [7:0] OP_LTA  = 8'h6C;
    localparam logic [7:0] OP_MPY  = 8'h6D;
    localparam logic [7:0] OP_LDP  = 8'h6F;
    localparam logic [7:0] OP_AND  = 8'h79;
    localparam logic [7:0] OP_OR   = 8'h7A;
    localparam logic [7:0] OP_LACK = 8'h7E;

    // Full-word opcodes.
    localparam logic [15:0] OP_NOP  = 16'h7F80;
    localparam logic [15:0] OP_ZAC  = 16'h7F89;
    localparam logic [15:0] OP_PAC  = 16'h7F8E;
    localparam logic [15:0] OP_APAC = 16'h7F8F;
    localparam logic [15:0] OP_SPAC = 16'h7F90;

    typedef enum logic [4:0] {
        I_NOP, I_ADD, I_SUB, I_LAC, I_ADDH, I_ADDS, I_LT, I_LTA, I_MPY,
        I_LDP, I_AND, I_OR, I_LACK, I_ZAC, I_PAC, I_APAC, I_SPAC
    } instr_e;

    // Anything not recognised decodes to I_NOP.
    function automatic instr_e decode(input logic [15:0] word);
        instr_e op;
        op = I_NOP;
        case (word[15:12])
            OP_ADD:  op = I_ADD;
            OP_SUB:  op = I_SUB;
            OP_LAC:  op = I_LAC;
            default: begin
                case (word[15:8])
                    OP_ADDH: op = I_ADDH;
                    OP_ADDS: op = I_ADDS;
                    OP_LT:   op = I_LT;
                    OP_LTA:  op = I_LTA;
                    OP_MPY:  op = I_MPY;
                    OP_LDP:  op = I_LDP;
                    OP_AND:  op = I_AND;
                    OP_OR:   op = I_OR;
                    OP_LACK: op = I_LACK;
                    default: begin
                        case (word)
                            OP_ZAC:  op = I_ZAC;
                            OP_PAC:  op = I_PAC;
                            OP_APAC: op = I_APAC;
                            OP_SPAC: op = I_SPAC;
                            default: op = I_NOP;
                        endcase
                    end
                endcase
            end
        endcase
        return op;
    endfunction

endpackage

// File: rtl/dsp_mem.sv
// dsp_mem: read-only 16-bit word memory with asynchronous read.
// Contents are preloaded externally through the hierarchical array 'mem'.
// Ports:
//   addr  - word address
//   rdata - word at mem[addr], combinational
module dsp_mem
    import dsp_pkg::*;
#(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 8
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    assign rdata = mem[addr];

endmodule

// File: rtl/dsp_core.sv
// dsp_core: single-cycle accumulator DSP. Fetches InstrMem[pc], reads
// DataMem[{dp, dma}] combinationally, and updates ACC/P/T/DP/PC on each
// rising clock edge. No branches; PC simply increments and wraps.
// Ports:
//   clk   - clock, all state on rising edge
//   reset - asynchronous active-low reset
//   pc    - program counter register
//   acc   - accumulator register
module dsp_core
    import dsp_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 4096,
    parameter int unsigned DMEM_DEPTH = 256
) (
    input  logic             clk,
    input  logic             reset,
    output logic [PC_W-1:0]  pc,
    output logic [ACC_W-1:0] acc
);

    localparam int unsigned DADDR_W = DMA_W + 1;

    logic [PC_W-1:0]    pc_q;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   p_q, p_d;
    logic [DATA_W-1:0]  t_q, t_d;
    logic               dp_q, dp_d;

    logic [DATA_W-1:0]  iword;
    logic [DATA_W-1:0]  dmem;
    logic [DADDR_W-1:0] daddr;
    instr_e             op;
    logic [3:0]         shamt;
    logic [ACC_W-1:0]   dsext;
    logic [ACC_W-1:0]   dshift;
    logic signed [ACC_W-1:0] prod;

    dsp_mem #(
        .DEPTH  (IMEM_DEPTH),
        .ADDR_W (PC_W)
    ) InstrMem (
        .addr  (pc_q),
        .rdata (iword)
    );

    assign daddr = {dp_q, iword[DMA_W-1:0]};

    dsp_mem #(
        .DEPTH  (DMEM_DEPTH),
        .ADDR_W (DADDR_W)
    ) DataMem (
        .addr  (daddr),
        .rdata (dmem)
    );

    assign op     = decode(iword);
    assign shamt  = iword[11:8];
    assign dsext  = {{(ACC_W-DATA_W){dmem[DATA_W-1]}}, dmem};
    assign dshift = dsext << shamt;
    assign prod   = $signed(t_q) * $signed(dmem);

    always_comb begin
        acc_d = acc_q;
        p_d   = p_q;
        t_d   = t_q;
        dp_d  = dp_q;
        unique case (op)
            I_ADD:  acc_d = acc_q + dshift;
            I_SUB:  acc_d = acc_q - dshift;
            I_LAC:  acc_d = dshift;
            I_ADDH: acc_d = acc_q + {dmem, 16'h0000};
            I_ADDS: acc_d = acc_q + {16'h0000, dmem};
            I_LT:   t_d   = dmem;
            I_LTA: begin
                t_d   = dmem;
                acc_d = acc_q + p_q;
            end
            I_MPY:  p_d   = prod;
            I_LDP:  dp_d  = dmem[0];
            I_AND:  acc_d = {16'h0000, acc_q[15:0] & dmem};
            I_OR:   acc_d = {acc_q[31:16], acc_q[15:0] | dmem};
            I_LACK: acc_d = {24'h000000, iword[7:0]};
            I_ZAC:  acc_d = '0;
            I_PAC:  acc_d = p_q;
            I_APAC: acc_d = acc_q + p_q;
            I_SPAC: acc_d = acc_q - p_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q  <= '0;
            acc_q <= '0;
            p_q   <= '0;
            t_q   <= '0;
            dp_q  <= 1'b0;
        end else begin
            pc_q  <= pc_q + 1'b1;
            acc_q <= acc_d;
            p_q   <= p_d;
            t_q   <= t_d;
            dp_q  <= dp_d;
        end
    end

    assign pc  = pc_q;
    assign acc = acc_q;

endmodule

// File: tb/tb_dsp_core.sv
// tb_dsp_core: directed-vector bench for dsp_core. Preloads instruction and
// data memories hierarchically, runs one straight-line program and checks
// ACC/PC (and P/T/DP internally) against hand-computed values, then covers
// PC wrap and a mid-program reset.
module tb_dsp_core;

    logic        clk;
    logic        reset;
    logic [11:0] pc;
    logic [31:0] acc;

    int unsigned n_checks;
    int unsigned n_errors;

    dsp_core #(
        .IMEM_DEPTH (4096),
        .DMEM_DEPTH (256)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .pc    (pc),
        .acc   (acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam int unsigned NPROG = 26;
    logic [15:0] prog [NPROG];
    logic [31:0] exp_acc [NPROG];

    initial begin
        prog[0]  = 16'h7EFF; exp_acc[0]  = 32'h0000_00FF; // LACK 0xFF
        prog[1]  = 16'h7F89; exp_acc[1]  = 32'h0000_0000; // ZAC
        prog[2]  = 16'h2005; exp_acc[2]  = 32'hFFFF_8000; // LAC 5
        prog[3]  = 16'h6105; exp_acc[3]  = 32'h0000_0000; // ADDS 5
        prog[4]  = 16'h6005; exp_acc[4]  = 32'h8000_0000; // ADDH 5
        prog[5]  = 16'h6A03; exp_acc[5]  = 32'h8000_0000; // LT 3
        prog[6]  = 16'h6D04; exp_acc[6]  = 32'h8000_0000; // MPY 4
        prog[7]  = 16'h7F8E; exp_acc[7]  = 32'hFFFF_FFFA; // PAC
        prog[8]  = 16'h7F8F; exp_acc[8]  = 32'hFFFF_FFF4; // APAC
        prog[9]  = 16'h7F90; exp_acc[9]  = 32'hFFFF_FFFA; // SPAC
        prog[10] = 16'h7F89; exp_acc[10] = 32'h0000_0000; // ZAC
        prog[11] = 16'h600C; exp_acc[11] = 32'h1234_0000; // ADDH 12
        prog[12] = 16'h610D; exp_acc[12] = 32'h1234_5678; // ADDS 13
        prog[13] = 16'h790A; exp_acc[13] = 32'h0000_0608; // AND 10
        prog[14] = 16'h7A0B; exp_acc[14] = 32'h0000_F608; // OR 11
        prog[15] = 16'h0405; exp_acc[15] = 32'hFFF8_F608; // ADD 5,<<4
        prog[16] = 16'h1204; exp_acc[16] = 32'hFFF8_F5FC; // SUB 4,<<2
        prog[17] = 16'h2F04; exp_acc[17] = 32'h0001_8000; // LAC 4,<<15
        prog[18] = 16'h6C04; exp_acc[18] = 32'h0001_7FFA; // LTA 4
        prog[19] = 16'h6D04; exp_acc[19] = 32'h0001_7FFA; // MPY 4
        prog[20] = 16'h7F8F; exp_acc[20] = 32'h0001_8003; // APAC
        prog[21] = 16'h5000; exp_acc[21] = 32'h0001_8003; // undefined
        prog[22] = 16'h7F80; exp_acc[22] = 32'h0001_8003; // NOP
        prog[23] = 16'h6F14; exp_acc[23] = 32'h0001_8003; // LDP 20
        prog[24] = 16'h2002; exp_acc[24] = 32'hFFFF_ABCD; // LAC 2 (page 1)
        prog[25] = 16'h7E12; exp_acc[25] = 32'h0000_0012; // LACK 0x12
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b0;

        for (int i = 0; i < 4096; i++) dut.InstrMem.mem[i] = 16'h0000;
        for (int i = 0; i < 256; i++)  dut.DataMem.mem[i]  = 16'h0000;
        #0;
        for (int i = 0; i < NPROG; i++) dut.InstrMem.mem[i] = prog[i];
        dut.DataMem.mem[2]   = 16'h0055;
        dut.DataMem.mem[3]   = 16'hFFFE;
        dut.DataMem.mem[4]   = 16'h0003;
        dut.DataMem.mem[5]   = 16'h8000;
        dut.DataMem.mem[10]  = 16'h0F0F;
        dut.DataMem.mem[11]  = 16'hF000;
        dut.DataMem.mem[12]  = 16'h1234;
        dut.DataMem.mem[13]  = 16'h5678;
        dut.DataMem.mem[20]  = 16'h0001;
        dut.DataMem.mem[130] = 16'hABCD;

        #2;
        check("reset_pc",  32'(pc), 32'h0);
        check("reset_acc", acc, 32'h0);
        check("reset_p",   dut.p_q, 32'h0);
        check("reset_t",   32'(dut.t_q), 32'h0);
        check("reset_dp",  32'(dut.dp_q), 32'h0);

        #8;            // t = 10 ns
        reset = 1'b1;
        #1;
        check("release_pc",  32'(pc), 32'h0);
        check("release_acc", acc, 32'h0);

        for (int i = 0; i < NPROG; i++) begin
            step();
            check($sformatf("acc_%0d", i), acc, exp_acc[i]);
            check($sformatf("pc_%0d", i), 32'(pc), 32'(i + 1));
            if (i == 6)  check("p_mpy1", dut.p_q, 32'hFFFF_FFFA);
            if (i == 18) check("t_lta",  32'(dut.t_q), 32'h0003);
            if (i == 19) check("p_mpy2", dut.p_q, 32'h0000_0009);
            if (i == 23) check("dp_ldp", 32'(dut.dp_q), 32'h1);
        end

        // Remaining words are ADD DataMem[128] (= 0) with DP=1: ACC holds.
        for (int i = NPROG; i < 4095; i++) step();
        check("pc_4095",  32'(pc), 32'd4095);
        check("acc_hold", acc, 32'h0000_0012);
        step();
        check("pc_wrap",     32'(pc), 32'h0);
        check("acc_wrap",    acc, 32'h0000_0012);
        step();
        check("pc_after_wrap",  32'(pc), 32'h1);
        check("acc_after_wrap", acc, 32'h0000_00FF);
        step();        // ZAC, then LAC 5 still on page 1 reads DataMem[133] = 0
        check("acc_zac_again", acc, 32'h0);

        // Mid-program asynchronous reset.
        #2;
        reset = 1'b0;
        #1;
        check("midrst_pc",  32'(pc), 32'h0);
        check("midrst_acc", acc, 32'h0);
        check("midrst_p",   dut.p_q, 32'h0);
        check("midrst_dp",  32'(dut.dp_q), 32'h0);
        step();
        check("midrst_hold_pc",  32'(pc), 32'h0);
        check("midrst_hold_acc", acc, 32'h0);
        #3;
        reset = 1'b1;
        step();
        check("restart_pc",  32'(pc), 32'h1);
        check("restart_acc", acc, 32'h0000_00FF);
        step();
        step();
        check("restart_lac_page0", acc, 32'hFFFF_8000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dsp_core.md
DSP_CORE -- requirements
Module: dsp_core

Interface
REQ-001 Parameter IMEM_DEPTH, default 4096, gives the instruction memory depth in 16-bit words; PC width is 12 bits.
REQ-002 Parameter DMEM_DEPTH, default 256, gives the data memory depth in 16-bit words; the address is {DP, dma[6:0]}.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 pc  output  12  current program counter (register value).
REQ-006 acc  output  32  current accumulator (register value).

Function
REQ-007 Execution SHALL be single-cycle: the instruction at InstrMem[pc] is read asynchronously, data memory is read asynchronously, and ACC, P, T, DP and PC update on the next rising clk edge.
REQ-008 Every cycle, PC SHALL become PC+1, wrapping from 4095 to 0; there are no branches.
REQ-009 Instruction word format: op[15:8], bit 7 ignored (direct addressing only), dma = [6:0], shift s = [11:8] for the shift-class instructions.
REQ-010 ADD (0x0s): ACC += sign-extended dmem << s.
REQ-011 SUB (0x1s): ACC -= sign-extended dmem << s.
REQ-012 LAC (0x2s): ACC = sign-extended dmem << s.
REQ-013 ADDH (0x60): ACC += dmem << 16.
REQ-014 ADDS (0x61): ACC += zero-extended dmem.
REQ-015 LT (0x6A): T = dmem.
REQ-016 LTA (0x6C): T = dmem and ACC += P, both in the same cycle.
REQ-017 MPY (0x6D): P = signed T x signed dmem, as a full 32-bit product.
REQ-018 LDP (0x6F): DP = dmem[0].
REQ-019 AND (0x79): ACC = {16'h0, ACC[15:0] & dmem}.
REQ-020 OR (0x7A): ACC[15:0] |= dmem; ACC[31:16] is unchanged.
REQ-021 LACK (0x7E): ACC = zero-extended word[7:0].
REQ-022 Full-word opcodes SHALL behave as follows:
- 0x7F89 ZAC: ACC = 0.
- 0x7F8E PAC: ACC = P.
- 0x7F8F APAC: ACC += P.
- 0x7F90 SPAC: ACC -= P.
- 0x7F80 NOP: no operation.
REQ-023 All ACC/P arithmetic SHALL be modulo 2^32, with no saturation and no overflow flag.
REQ-024 Undefined opcodes SHALL execute as NOP, with PC still advancing.
REQ-025 Data memory is never written by the supported instruction set; instruction memory is read-only.

Reset
REQ-026 While reset=0, PC, ACC, P, T and DP SHALL be 0, regardless of clk.
REQ-027 The first instruction executed after reset deasserts is InstrMem[0].
REQ-028 Memory contents SHALL NOT be altered by reset.
REQ-029 Reset asserted mid-program SHALL abandon the current instruction with no partial register update.

Structure
REQ-030 Shared package dsp_pkg holds:
- opcode constants;
- widths: ACC/P 32, T/data 16, PC 12, dma 7.
REQ-031 A single sub-module dsp_mem (16-bit wide, depth parameter, asynchronous read, storage array named mem) SHALL be used, with two instances:
- InstrMem, depth IMEM_DEPTH;
- DataMem, depth DMEM_DEPTH.
REQ-032 The InstrMem.mem and DataMem.mem arrays SHALL be preloadable via hierarchical $readmemb.
REQ-033 Decode, the ALU and the registers SHALL reside in dsp_core.

Verification
REQ-034 Hold reset=0 for 10 ns, then release -> pc=0 and acc=0, after which pc increments by 1 per clock.
REQ-035 Run LACK 0xFF, then ZAC -> acc=0x000000FF, then 0x00000000.
REQ-036 With DataMem[5]=0x8000, run LAC 5, then ADDS 5, then ADDH 5:
- after LAC 5, acc=0xFFFF8000;
- after ADDS 5, acc=0x00000000;
- after ADDH 5, acc=0x80000000.
REQ-037 With DataMem[3]=0xFFFE and DataMem[4]=0x0003, run LT 3, MPY 4, PAC, APAC, SPAC:
- after MPY 4, P=0xFFFFFFFA;
- after PAC, acc=0xFFFFFFFA;
- after APAC, acc=0xFFFFFFF4;
- after SPAC, acc=0xFFFFFFFA.
REQ-038 With acc=0x12345678 and dmem=0x0F0F, run AND; then with dmem=0xF000, run OR:
- after AND, acc=0x00000608;
- after OR, acc=0x0000F608.
REQ-039 Execute LDP on a word holding 1, then LAC 2 -> acc equals DataMem[130]; PC wraps from 4095 to 0.
